// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters with registered sync, display-enable
// and line/frame strobes, all aligned to the counter values they describe.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    output logic [CW-1:0] xcounter,
    output logic [CW-1:0] ycounter,
    output logic          hsync,
    output logic          vsync,
    output logic          inDisplayArea,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic          x_wrap, y_wrap;
    logic [CW-1:0] x_nxt, y_nxt;
    logic          hs_act, vs_act, de_nxt;

    // Decode on the next counter values so the registered outputs line up with the counters.
    always_comb begin
        x_wrap = (xcounter == H_LAST);
        y_wrap = (ycounter == V_LAST);
        x_nxt  = x_wrap ? '0 : xcounter + CW'(1);
        y_nxt  = ycounter;
        if (x_wrap)
            y_nxt = y_wrap ? '0 : ycounter + CW'(1);
        // int compares keep sync-end bounds safe when they equal the total
        hs_act = (int'(x_nxt) >= H_ACTIVE + H_FP) && (int'(x_nxt) < H_ACTIVE + H_FP + H_SYNC);
        vs_act = (int'(y_nxt) >= V_ACTIVE + V_FP) && (int'(y_nxt) < V_ACTIVE + V_FP + V_SYNC);
        de_nxt = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xcounter      <= H_LAST;
            ycounter      <= V_LAST;
            hsync         <= ~HS_POL;
            vsync         <= ~VS_POL;
            inDisplayArea <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            line_start  <= pix_en & x_wrap;
            frame_start <= pix_en & x_wrap & y_wrap;
            if (pix_en) begin
                xcounter      <= x_nxt;
                ycounter      <= y_nxt;
                hsync         <= hs_act ? HS_POL : ~HS_POL;
                vsync         <= vs_act ? VS_POL : ~VS_POL;
                inDisplayArea <= de_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing at half-rate pix_en, a short-frame variant for
// full-frame vertical checks and async reset, and a tiny active-high config.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // default config, pix_en driven by tasks
    logic       rst_d = 1'b0, pe = 1'b0;
    logic [9:0] x_d, y_d;
    logic       hs_d, vs_d, de_d, ls_d, fs_d;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_d), .pix_en(pe),
        .xcounter(x_d), .ycounter(y_d), .hsync(hs_d), .vsync(vs_d),
        .inDisplayArea(de_d), .line_start(ls_d), .frame_start(fs_d)
    );

    // default horizontal, short vertical (V_TOTAL = 10), pix_en tied high
    logic       rst_m = 1'b0;
    logic [9:0] x_m, y_m;
    logic       hs_m, vs_m, de_m, ls_m, fs_m;

    vga_timing_gen #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_mid (
        .clk(clk), .rst_n(rst_m), .pix_en(1'b1),
        .xcounter(x_m), .ycounter(y_m), .hsync(hs_m), .vsync(vs_m),
        .inDisplayArea(de_m), .line_start(ls_m), .frame_start(fs_m)
    );

    // tiny config, active-high syncs, pix_en tied high
    logic       rst_s = 1'b0;
    logic [2:0] x_s, y_s;
    logic       hs_s, vs_s, de_s, ls_s, fs_s;

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .CW(3)) u_sml (
        .clk(clk), .rst_n(rst_s), .pix_en(1'b1),
        .xcounter(x_s), .ycounter(y_s), .hsync(hs_s), .vsync(vs_s),
        .inDisplayArea(de_s), .line_start(ls_s), .frame_start(fs_s)
    );

    // one pix_en edge, sampled 1 time unit later; gap() is the idle clk between
    task automatic pe_step();
        pe = 1'b1;
        @(posedge clk); #1;
        pe = 1'b0;
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (x_d !== 10'd799) begin errors++; $display("FAIL rst_x got %0d want 799", x_d); end
        checks++; if (y_d !== 10'd524) begin errors++; $display("FAIL rst_y got %0d want 524", y_d); end
        checks++; if ({hs_d, vs_d, de_d, ls_d, fs_d} !== 5'b11000)
            begin errors++; $display("FAIL rst_flags got %b want 11000", {hs_d, vs_d, de_d, ls_d, fs_d}); end
        checks++; if ({x_s, y_s, hs_s, vs_s, de_s} !== {3'd7, 3'd5, 3'b000})
            begin errors++; $display("FAIL rst_small got x%0d y%0d %b want x7 y5 000", x_s, y_s, {hs_s, vs_s, de_s}); end
        rst_d = 1'b1;
        gap();
        checks++; if (x_d !== 10'd799 || ls_d !== 1'b0)
            begin errors++; $display("FAIL rst_release_hold got x%0d ls%b want x799 ls0", x_d, ls_d); end
    endtask

    task automatic test_first_pixel();
        pe_step();
        checks++; if (x_d !== 10'd0 || y_d !== 10'd0)
            begin errors++; $display("FAIL first_xy got (%0d,%0d) want (0,0)", x_d, y_d); end
        checks++; if ({de_d, ls_d, fs_d, hs_d, vs_d} !== 5'b11111)
            begin errors++; $display("FAIL first_flags got %b want 11111", {de_d, ls_d, fs_d, hs_d, vs_d}); end
        gap();
        checks++; if (ls_d !== 1'b0 || fs_d !== 1'b0 || x_d !== 10'd0)
            begin errors++; $display("FAIL first_strobe_width got ls%b fs%b x%0d want ls0 fs0 x0", ls_d, fs_d, x_d); end
    endtask

    task automatic test_horizontal();
        int xbad = 0, hs_lo = 0, hs_lo_out = 0, ls_cnt = 0;
        for (int i = 1; i < 800; i++) begin
            pe_step();
            if (x_d !== i[9:0]) xbad++;
            if (hs_d === 1'b0) begin hs_lo++; if (i < 656 || i > 751) hs_lo_out++; end
            if (ls_d !== 1'b0 || fs_d !== 1'b0) ls_cnt++;
            if (i == 639) begin checks++; if (de_d !== 1'b1) begin errors++; $display("FAIL de_x639 got %b want 1", de_d); end end
            if (i == 640) begin checks++; if (de_d !== 1'b0) begin errors++; $display("FAIL de_x640 got %b want 0", de_d); end end
            if (i == 655) begin checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL hs_x655 got %b want 1", hs_d); end end
            if (i == 656) begin checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL hs_x656 got %b want 0", hs_d); end end
            if (i == 751) begin checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL hs_x751 got %b want 0", hs_d); end end
            if (i == 752) begin checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL hs_x752 got %b want 1", hs_d); end end
            if (i == 799) begin checks++; if (y_d !== 10'd0) begin errors++; $display("FAIL y_x799 got %0d want 0", y_d); end end
            gap();
        end
        checks++; if (xbad != 0) begin errors++; $display("FAIL x_sequence got %0d bad want 0", xbad); end
        checks++; if (hs_lo != 96) begin errors++; $display("FAIL hs_width got %0d want 96", hs_lo); end
        checks++; if (hs_lo_out != 0) begin errors++; $display("FAIL hs_window got %0d outside want 0", hs_lo_out); end
        checks++; if (ls_cnt != 0) begin errors++; $display("FAIL strobe_midline got %0d want 0", ls_cnt); end
        pe_step();
        checks++; if (x_d !== 10'd0 || y_d !== 10'd1)
            begin errors++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", x_d, y_d); end
        checks++; if ({ls_d, fs_d, de_d} !== 3'b101)
            begin errors++; $display("FAIL line_strobe got %b want 101", {ls_d, fs_d, de_d}); end
        gap();
    endtask

    task automatic test_pix_hold();
        int bad = 0;
        repeat (300) begin pe_step(); gap(); end
        checks++; if (x_d !== 10'd300 || y_d !== 10'd1)
            begin errors++; $display("FAIL hold_start got (%0d,%0d) want (300,1)", x_d, y_d); end
        repeat (100) begin
            gap();
            if (x_d !== 10'd300 || y_d !== 10'd1 || {hs_d, vs_d, de_d, ls_d, fs_d} !== 5'b11100) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_outputs got %0d bad cycles want 0", bad); end
        pe_step();
        checks++; if (x_d !== 10'd301 || y_d !== 10'd1)
            begin errors++; $display("FAIL hold_resume got (%0d,%0d) want (301,1)", x_d, y_d); end
    endtask

    task automatic test_vertical();
        int period = 0, vs_lo = 0, vs_lo_out = 0, vs_off_x0 = 0, de_cnt = 0, de_out = 0, hs_lo = 0, ls_cnt = 0;
        logic vs_prev;
        @(posedge clk); #1;
        rst_m = 1'b1;
        gap();
        checks++; if (x_m !== 10'd0 || y_m !== 10'd0 || fs_m !== 1'b1)
            begin errors++; $display("FAIL mid_first got (%0d,%0d) fs%b want (0,0) fs1", x_m, y_m, fs_m); end
        vs_prev = vs_m;
        for (int n = 0; n < 9000; n++) begin
            if (vs_m === 1'b0) begin vs_lo++; if (y_m != 7 && y_m != 8) vs_lo_out++; end
            if (vs_m !== vs_prev && x_m !== 10'd0) vs_off_x0++;
            if (de_m === 1'b1) begin de_cnt++; if (y_m >= 6 || x_m >= 640) de_out++; end
            if (hs_m === 1'b0) hs_lo++;
            if (ls_m === 1'b1) ls_cnt++;
            vs_prev = vs_m;
            gap();
            period++;
            if (fs_m === 1'b1) break;
        end
        checks++; if (period != 8000) begin errors++; $display("FAIL frame_period got %0d want 8000", period); end
        checks++; if (vs_lo != 1600) begin errors++; $display("FAIL vs_width got %0d want 1600", vs_lo); end
        checks++; if (vs_lo_out != 0) begin errors++; $display("FAIL vs_window got %0d outside want 0", vs_lo_out); end
        checks++; if (vs_off_x0 != 0) begin errors++; $display("FAIL vs_edge_x got %0d off x0 want 0", vs_off_x0); end
        checks++; if (de_cnt != 3840) begin errors++; $display("FAIL de_count got %0d want 3840", de_cnt); end
        checks++; if (de_out != 0) begin errors++; $display("FAIL de_window got %0d outside want 0", de_out); end
        checks++; if (hs_lo != 960) begin errors++; $display("FAIL hs_frame got %0d want 960", hs_lo); end
        checks++; if (ls_cnt != 10) begin errors++; $display("FAIL line_count got %0d want 10", ls_cnt); end
    endtask

    task automatic test_async_reset();
        repeat (1723) gap();
        checks++; if (x_m !== 10'd123 || y_m !== 10'd2)
            begin errors++; $display("FAIL areset_pos got (%0d,%0d) want (123,2)", x_m, y_m); end
        #2 rst_m = 1'b0;
        #1;
        checks++; if (x_m !== 10'd799 || y_m !== 10'd9)
            begin errors++; $display("FAIL areset_xy got (%0d,%0d) want (799,9)", x_m, y_m); end
        checks++; if ({hs_m, vs_m, de_m, ls_m, fs_m} !== 5'b11000)
            begin errors++; $display("FAIL areset_flags got %b want 11000", {hs_m, vs_m, de_m, ls_m, fs_m}); end
        repeat (3) @(posedge clk);
        #1 rst_m = 1'b1;
        gap();
        checks++; if (x_m !== 10'd0 || y_m !== 10'd0 || {fs_m, ls_m, de_m} !== 3'b111)
            begin errors++; $display("FAIL areset_restart got (%0d,%0d) %b want (0,0) 111", x_m, y_m, {fs_m, ls_m, de_m}); end
    endtask

    task automatic test_small();
        int period = 0, hs_hi = 0, hs_out = 0, vs_hi = 0, vs_out = 0, de_cnt = 0;
        @(posedge clk); #1;
        rst_s = 1'b1;
        gap();
        checks++; if (x_s !== 3'd0 || y_s !== 3'd0 || fs_s !== 1'b1)
            begin errors++; $display("FAIL small_first got (%0d,%0d) fs%b want (0,0) fs1", x_s, y_s, fs_s); end
        for (int n = 0; n < 100; n++) begin
            if (hs_s === 1'b1) begin hs_hi++; if (x_s != 5 && x_s != 6) hs_out++; end
            if (vs_s === 1'b1) begin vs_hi++; if (y_s != 4) vs_out++; end
            if (de_s === 1'b1) de_cnt++;
            gap();
            period++;
            if (fs_s === 1'b1) break;
        end
        checks++; if (period != 48) begin errors++; $display("FAIL small_period got %0d want 48", period); end
        checks++; if (hs_hi != 12 || hs_out != 0)
            begin errors++; $display("FAIL small_hs got %0d high %0d outside want 12 0", hs_hi, hs_out); end
        checks++; if (vs_hi != 8 || vs_out != 0)
            begin errors++; $display("FAIL small_vs got %0d high %0d outside want 8 0", vs_hi, vs_out); end
        checks++; if (de_cnt != 12) begin errors++; $display("FAIL small_de got %0d want 12", de_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_horizontal();
        test_pix_hold();
        test_vertical();
        test_async_reset();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
